// File: rtl/cache_refill_if.sv
// Bundle of the refill engine's cache-side and memory-side signals.
// The slave modport is the refill engine; the master modport is the
// cache/memory environment that drives requests and returns read data.
interface cache_refill_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
);
    localparam int S = 1 << BLOCK_SIZE;

    logic                      req_valid;
    logic [ADDRESS_WIDTH-1:0]  req_addr;
    logic                      busy;
    logic                      block_valid;
    logic [DATA_WIDTH*S-1:0]   block_data;
    logic [ADDRESS_WIDTH-1:0]  block_addr;
    logic                      mem_rd_en;
    logic [ADDRESS_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rd_data;

    modport master (
        output req_valid, req_addr, mem_rd_data,
        input  busy, block_valid, block_data, block_addr, mem_rd_en, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, mem_rd_data,
        output busy, block_valid, block_data, block_addr, mem_rd_en, mem_addr
    );
endinterface

// File: rtl/cache_refill.sv
// Miss-refill engine: fetches an aligned block of 2^BLOCK_SIZE words from a
// one-cycle-latency memory, assembles it into one wide bus and pulses
// block_valid for the cache fill. The core is stalled while fetching.
module cache_refill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
) (
    input  logic          clk,
    input  logic          rst,
    cache_refill_if.slave bus
);
    localparam int S  = 1 << BLOCK_SIZE;
    localparam int CW = BLOCK_SIZE + 1;
    localparam logic [CW-1:0]            S_CNT    = CW'(S);
    localparam logic [CW-1:0]            LAST_CNT = CW'(S - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'(S - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [CW-1:0]              issue_cnt_reg, issue_cnt_next;
    logic [CW-1:0]              recv_cnt_reg, recv_cnt_next;
    logic [ADDRESS_WIDTH-1:0]   base_reg, base_next;
    logic [ADDRESS_WIDTH-1:0]   block_addr_reg, block_addr_next;
    logic [DATA_WIDTH*S-1:0]    block_data_reg;
    logic                       rd_pending_reg;
    logic                       issue_en;
    logic                       capture;
    logic [S-1:0]               wr_sel;

    // A read is outstanding in the cycle after each issue; only then is
    // mem_rd_data meaningful. Cleared by reset so late data is dropped.
    assign issue_en = (state_reg == FETCH) && (issue_cnt_reg < S_CNT);
    assign capture  = (state_reg == FETCH) && rd_pending_reg;

    // One write-select per word lane of the assembled block.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : gen_sel
            assign wr_sel[gi] = capture && (recv_cnt_reg == CW'(gi));
        end
    endgenerate

    // State, counters and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            issue_cnt_reg  <= '0;
            recv_cnt_reg   <= '0;
            base_reg       <= '0;
            block_addr_reg <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            issue_cnt_reg  <= issue_cnt_next;
            recv_cnt_reg   <= recv_cnt_next;
            base_reg       <= base_next;
            block_addr_reg <= block_addr_next;
            rd_pending_reg <= issue_en;
        end
    end

    // Next-state logic: accept a miss, stream issues and captures, finish.
    always_comb begin
        state_next      = state_reg;
        issue_cnt_next  = issue_cnt_reg;
        recv_cnt_next   = recv_cnt_reg;
        base_next       = base_reg;
        block_addr_next = block_addr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    base_next      = bus.req_addr & ~LOW_MASK;
                    issue_cnt_next = '0;
                    recv_cnt_next  = '0;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                if (issue_en) begin
                    issue_cnt_next = issue_cnt_reg + 1'b1;
                end
                if (capture) begin
                    recv_cnt_next = recv_cnt_reg + 1'b1;
                    if (recv_cnt_reg == LAST_CNT) begin
                        block_addr_next = base_reg;
                        state_next      = DONE;
                    end
                end
            end
            DONE: begin
                // The cache still reports the same miss here; ignore it.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block assembly: each returning word lands in its lane; lanes not yet
    // refilled keep their previous contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_data_reg <= '0;
        end else begin
            for (int i = 0; i < S; i++) begin
                if (wr_sel[i]) begin
                    block_data_reg[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rd_data;
                end
            end
        end
    end

    // Base is aligned, so adding the issue count never carries out of the block.
    assign bus.mem_rd_en   = issue_en;
    assign bus.mem_addr    = issue_en ? (base_reg + ADDRESS_WIDTH'(issue_cnt_reg)) : '0;
    assign bus.busy        = (state_reg == FETCH) || ((state_reg == IDLE) && bus.req_valid);
    assign bus.block_valid = (state_reg == DONE);
    assign bus.block_data  = block_data_reg;
    assign bus.block_addr  = block_addr_reg;
endmodule
